mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3b_types.sv | 5 +
 rtl/mem_arbiter.sv | 76 +++++++
 2 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word and cache-line types.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between the I-cache and D-cache,
// alternating grants under contention and holding the command stable until pmem_resp.
module mem_arbiter
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  lc3b_word i_pmem_address,
    input  logic     i_pmem_read,
    output logic     i_pmem_resp,
    output lc3b_line i_pmem_rdata,
    input  lc3b_word d_pmem_address,
    input  logic     d_pmem_read,
    input  logic     d_pmem_write,
    input  lc3b_line d_pmem_wdata,
    output logic     d_pmem_resp,
    output lc3b_line d_pmem_rdata,
    output lc3b_word pmem_address,
    output logic     pmem_read,
    output logic     pmem_write,
    output lc3b_line pmem_wdata,
    input  logic     pmem_resp,
    input  lc3b_line pmem_rdata
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;
    state_t   r_state;
    logic     r_last_d;
    lc3b_line r_i_rdata;
    lc3b_line r_d_rdata;
    logic     w_i_req;
    logic     w_d_req;
    logic     w_pick_d;
    assign w_i_req  = i_pmem_read;
    assign w_d_req  = d_pmem_read | d_pmem_write;
    // D wins a tie only when I was granted last
    assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);
    // resp is gated by reset so a same-cycle reset suppresses completion
    assign i_pmem_resp  = reset & pmem_resp & (r_state == GRANT_I);
    assign d_pmem_resp  = reset & pmem_resp & (r_state == GRANT_D);
    assign i_pmem_rdata = (r_state == GRANT_I) ? pmem_rdata : r_i_rdata;
    assign d_pmem_rdata = (r_state == GRANT_D) ? pmem_rdata : r_d_rdata;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_d     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            pmem_address <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_i_req | w_d_req) begin
                    r_state      <= w_pick_d ? GRANT_D : GRANT_I;
                    r_last_d     <= w_pick_d;
                    pmem_address <= w_pick_d ? d_pmem_address : i_pmem_address;
                    pmem_read    <= ~(w_pick_d & d_pmem_write);
                    pmem_write   <= w_pick_d & d_pmem_write;
                    if (w_pick_d)
                        pmem_wdata <= d_pmem_wdata;
                end
                GRANT_I, GRANT_D: if (pmem_resp) begin
                    r_state    <= DONE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                    if (r_state == GRANT_I)
                        r_i_rdata <= pmem_rdata;
                    else
                        r_d_rdata <= pmem_rdata;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
